exec_wb_stage: RTL and testbench
================================

EXEC_WB_STAGE -- requirements
Module: exec_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width (must match register-file data width).
REQ-002 SHALL have parameter ADDR_W, default 3, register address width (8 registers).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1: operation handshake, transfer when both high on a clk edge.
REQ-006 SHALL have ports op input 4 (opcode), rd input ADDR_W (destination), opa input DATA_W, opb input DATA_W (operands, from register-file QA/QB).
REQ-007 SHALL have ports wb_we output 1, wb_addr output ADDR_W, wb_data output DATA_W: write port driving register-file we/addre_wr/D.
REQ-008 SHALL have ports busy output 1, flag_z output 1, flag_c output 1, illegal output 1 (one-cycle pulse).

Function
REQ-009 SHALL implement ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL by opb[3:0], 6 SHR logical by opb[3:0], 7 MOV (result=opb), 8 CMP (opa-opb, flags only, no write), 9 MUL; 10-15 undefined.
REQ-010 SHALL use FSM states IDLE and MUL; IDLE->MUL on accepted MUL, MUL->IDLE after 16th iteration; in_ready=1 exactly in IDLE.
REQ-011 SHALL, for ops 0-7 accepted at edge N, drive wb_we=1 with wb_addr=rd, wb_data=result during cycle N+1 only (latency 1); back-to-back acceptance SHALL give back-to-back writes.
REQ-012 SHALL compute MUL by 16-iteration shift-add, busy=1 during MUL state, and write low DATA_W bits of product with wb_we=1 in cycle N+17 (one cycle).
REQ-013 SHALL compute ADD/SUB/CMP modulo 2^DATA_W; flag_c = carry-out for ADD, borrow (opa<opb unsigned) for SUB/CMP; flag_z = result==0.
REQ-014 SHALL update flags only on ADD, SUB, CMP (both flags) and AND/OR/XOR/MUL (flag_z only, flag_c cleared); other ops hold flags.
REQ-015 SHALL, on undefined opcode accepted, perform no write, hold flags, pulse illegal=1 in cycle N+1.
REQ-016 SHALL treat shift amounts 0 as pass-through and >=DATA_W impossible (4-bit field).
REQ-017 SHALL hold wb_we=0 in every cycle not named above; wb_addr/wb_data hold last value when wb_we=0.
REQ-018 SHALL ignore in_valid while in_ready=0 (no implicit queue); upstream holds op/operands stable until transfer.
REQ-019 SHALL not forward results; a read of rd is valid from the cycle after wb_we.

Reset
REQ-020 SHALL, when rst_n=0 at a clk edge, set state IDLE, wb_we=0, wb_addr=0, wb_data=0, busy=0, flag_z=0, flag_c=0, illegal=0, in_ready=1 from next cycle.
REQ-021 SHALL, on reset mid-MUL, abort the multiply with no write-back.

Configuration
REQ-022 SHALL honour macro EXEC_WB_MUL_EN: defined -> MUL per REQ-012; undefined -> no MUL state/datapath, opcode 9 treated as undefined per REQ-015, busy tied 0.

Structure
REQ-023 SHALL take opcode enum, DATA_W/ADDR_W defaults and MUL iteration count from shared package exec_pkg.
REQ-024 SHALL place combinational ops 0-8 in one sub-module alu16 (inputs op/opa/opb, outputs result/carry/zero); FSM, multiplier and write-back registers stay in exec_wb_stage.

Verification
REQ-025 SHALL cover ADD opa=16'hFFFF opb=16'h0001 rd=3 -> cycle N+1 wb_we=1 wb_addr=3 wb_data=0, flag_z=1 flag_c=1.
REQ-026 SHALL cover back-to-back SUB 5-7 rd=1 then CMP 7-7 -> writes 16'hFFFE to r1 with flag_c=1, then no write, flag_z=1 flag_c=0.
REQ-027 SHALL cover MUL 300*300 rd=6 -> in_ready=0 for 16 cycles, N+17 wb_we=1 wb_data=16'h5F90, new in_valid held meanwhile accepted only after.
REQ-028 SHALL cover op=4'hC -> no wb_we, illegal pulse at N+1, flags unchanged.
REQ-029 SHALL cover rst_n=0 at MUL iteration 8 -> no write ever, all outputs zero, in_ready=1 after release.
REQ-030 SHALL cover build without EXEC_WB_MUL_EN: opcode 9 -> illegal pulse, no write, busy stays 0.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the execute/write-back stage.
//   - DataWDefault / AddrWDefault : default operand and register-address widths
//   - MulIters                    : shift-add iterations per multiply
//   - op_e                        : opcode encoding (10-15 are undefined)
package exec_pkg;

  localparam int unsigned DataWDefault = 16;
  localparam int unsigned AddrWDefault = 3;
  localparam int unsigned MulIters     = 16;

  typedef enum logic [3:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpAnd = 4'd2,
    OpOr  = 4'd3,
    OpXor = 4'd4,
    OpShl = 4'd5,
    OpShr = 4'd6,
    OpMov = 4'd7,
    OpCmp = 4'd8,
    OpMul = 4'd9
  } op_e;

endpackage

// File: rtl/alu16.sv
// alu16: purely combinational ALU for opcodes 0-8 (everything except MUL).
// Ports:
//   op     - opcode (exec_pkg::op_e encoding)
//   opa    - first operand
//   opb    - second operand; opb[3:0] is the shift amount for SHL/SHR
//   result - operation result (0 for opcodes this unit does not handle)
//   carry  - carry-out for ADD, borrow (opa < opb unsigned) for SUB/CMP, else 0
//   zero   - result == 0
module alu16
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum    = {1'b0, opa} + {1'b0, opb};
    // Top bit of the widened difference is the unsigned borrow.
    diff   = {1'b0, opa} - {1'b0, opb};
    result = '0;
    carry  = 1'b0;
    case (op)
      OpAdd: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OpSub, OpCmp: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      OpAnd:   result = opa & opb;
      OpOr:    result = opa | opb;
      OpXor:   result = opa ^ opb;
      OpShl:   result = opa << opb[3:0];
      OpShr:   result = opa >> opb[3:0];
      OpMov:   result = opb;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/exec_wb_stage.sv
// exec_wb_stage: execute stage with a registered write-back port to the register file.
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   in_valid / in_ready         - operation handshake (in_ready high only when idle)
//   op, rd, opa, opb            - opcode, destination register, operands
//   wb_we, wb_addr, wb_data     - register-file write port (one-cycle write strobe)
//   busy                        - multiply in progress
//   flag_z, flag_c              - zero / carry-borrow flags
//   illegal                     - one-cycle pulse after an undefined opcode is accepted
// Build option: define EXEC_WB_MUL_EN to include the 16-iteration shift-add multiplier;
// without it opcode 9 is treated as undefined and busy is tied low.
module exec_wb_stage
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              flag_z,
  output logic              flag_c,
  output logic              illegal
);

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  alu16 #(.DATA_W(DATA_W)) u_alu (
    .op    (op),
    .opa   (opa),
    .opb   (opb),
    .result(alu_result),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  logic              wb_we_d, wb_we_q;
  logic [ADDR_W-1:0] wb_addr_d, wb_addr_q;
  logic [DATA_W-1:0] wb_data_d, wb_data_q;
  logic              flag_z_d, flag_z_q;
  logic              flag_c_d, flag_c_q;
  logic              illegal_d, illegal_q;
  logic              accept;

`ifdef EXEC_WB_MUL_EN
  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e            state_d, state_q;
  logic [DATA_W-1:0] mcand_d, mcand_q;
  logic [DATA_W-1:0] mplier_d, mplier_q;
  logic [DATA_W-1:0] acc_d, acc_q;
  logic [DATA_W-1:0] acc_step;
  logic [ADDR_W-1:0] mul_rd_d, mul_rd_q;
  logic [4:0]        iter_d, iter_q;

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q == StMul);
`else
  assign in_ready = 1'b1;
  assign busy     = 1'b0;
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    wb_we_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    illegal_d = 1'b0;
`ifdef EXEC_WB_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mul_rd_d = mul_rd_q;
    iter_d   = iter_q;
    // Only the low DATA_W product bits are kept, so bits shifted out of mcand are dropped.
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (state_q == StMul) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      iter_d   = iter_q + 5'd1;
      if (iter_q == 5'(MulIters - 1)) begin
        state_d   = StIdle;
        wb_we_d   = 1'b1;
        wb_addr_d = mul_rd_q;
        wb_data_d = acc_step;
        flag_z_d  = (acc_step == '0);
        flag_c_d  = 1'b0;
      end
    end
`endif
    if (accept) begin
      case (op)
        OpAdd, OpSub: begin
          wb_we_d   = 1'b1;
          wb_addr_d = rd;
          wb_data_d = alu_result;
          flag_z_d  = alu_zero;
          flag_c_d  = alu_carry;
        end
        OpAnd, OpOr, OpXor: begin
          wb_we_d   = 1'b1;
          wb_addr_d = rd;
          wb_data_d = alu_result;
          flag_z_d  = alu_zero;
          flag_c_d  = 1'b0;
        end
        OpShl, OpShr, OpMov: begin
          wb_we_d   = 1'b1;
          wb_addr_d = rd;
          wb_data_d = alu_result;
        end
        OpCmp: begin
          flag_z_d = alu_zero;
          flag_c_d = alu_carry;
        end
`ifdef EXEC_WB_MUL_EN
        OpMul: begin
          state_d  = StMul;
          mcand_d  = opa;
          mplier_d = opb;
          acc_d    = '0;
          mul_rd_d = rd;
          iter_d   = '0;
        end
`endif
        default: illegal_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      illegal_q <= 1'b0;
`ifdef EXEC_WB_MUL_EN
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mul_rd_q <= '0;
      iter_q   <= '0;
`endif
    end else begin
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
      illegal_q <= illegal_d;
`ifdef EXEC_WB_MUL_EN
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mul_rd_q <= mul_rd_d;
      iter_q   <= iter_d;
`endif
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign flag_z  = flag_z_q;
  assign flag_c  = flag_c_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_exec_wb_stage.sv
// tb_exec_wb_stage: directed self-checking bench for exec_wb_stage.
// Covers reset, every defined ALU op, flag hold/update rules, back-to-back writes,
// undefined opcodes and, when EXEC_WB_MUL_EN is defined, multiply timing and abort.
module tb_exec_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [2:0]  rd;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        busy;
  logic        flag_z;
  logic        flag_c;
  logic        illegal;

  int unsigned tests;
  int unsigned fails;

  exec_wb_stage #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op      (op),
    .rd      (rd),
    .opa     (opa),
    .opb     (opb),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .busy    (busy),
    .flag_z  (flag_z),
    .flag_c  (flag_c),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Sample 1 time unit after the rising edge, well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [2:0] r, input logic [15:0] a,
                       input logic [15:0] b);
    in_valid = 1'b1;
    op       = o;
    rd       = r;
    opa      = a;
    opb      = b;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Check a one-cycle write in the cycle after acceptance.
  task automatic expect_wr(input string tag, input logic [2:0] a, input logic [15:0] d,
                           input logic z, input logic c);
    check({tag, ".we"}, {31'd0, wb_we}, 32'd1);
    check({tag, ".addr"}, {29'd0, wb_addr}, {29'd0, a});
    check({tag, ".data"}, {16'd0, wb_data}, {16'd0, d});
    check({tag, ".flags"}, {30'd0, flag_z, flag_c}, {30'd0, z, c});
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, ".we"}, {31'd0, wb_we}, 32'd0);
    check({tag, ".addr"}, {29'd0, wb_addr}, 32'd0);
    check({tag, ".data"}, {16'd0, wb_data}, 32'd0);
    check({tag, ".flags"}, {30'd0, flag_z, flag_c}, 32'd0);
    check({tag, ".illegal"}, {31'd0, illegal}, 32'd0);
    check({tag, ".busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic saw_we;
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op       = 4'd0;
    rd       = 3'd0;
    opa      = 16'd0;
    opb      = 16'd0;
    tick();
    tick();
    expect_reset_outputs("reset");
    rst_n = 1'b1;

    // ADD wrap-around, then back-to-back SUB and CMP.
    drive(4'd0, 3'd3, 16'hFFFF, 16'h0001);
    tick();
    expect_wr("add_wrap", 3'd3, 16'h0000, 1'b1, 1'b1);
    drive(4'd1, 3'd1, 16'd5, 16'd7);
    tick();
    expect_wr("sub_borrow", 3'd1, 16'hFFFE, 1'b0, 1'b1);
    drive(4'd8, 3'd6, 16'd7, 16'd7);
    tick();
    check("cmp.we", {31'd0, wb_we}, 32'd0);
    check("cmp.flags", {30'd0, flag_z, flag_c}, 32'b10);
    check("cmp.hold_data", {16'd0, wb_data}, 32'h0000_FFFE);
    check("cmp.hold_addr", {29'd0, wb_addr}, 32'd1);

    // Logic ops update z and clear c.
    drive(4'd2, 3'd2, 16'hF0F0, 16'h0FF0);
    tick();
    expect_wr("and", 3'd2, 16'h00F0, 1'b0, 1'b0);
    drive(4'd3, 3'd4, 16'h1200, 16'h0034);
    tick();
    expect_wr("or", 3'd4, 16'h1234, 1'b0, 1'b0);
    drive(4'd4, 3'd5, 16'hAAAA, 16'hAAAA);
    tick();
    expect_wr("xor", 3'd5, 16'h0000, 1'b1, 1'b0);

    // Shifts and MOV leave flags alone (z=1, c=0 from XOR).
    drive(4'd5, 3'd7, 16'h0001, 16'h0004);
    tick();
    expect_wr("shl4", 3'd7, 16'h0010, 1'b1, 1'b0);
    drive(4'd6, 3'd7, 16'h8000, 16'h000F);
    tick();
    expect_wr("shr15", 3'd7, 16'h0001, 1'b1, 1'b0);
    drive(4'd5, 3'd3, 16'h1234, 16'h0010);
    tick();
    expect_wr("shl0", 3'd3, 16'h1234, 1'b1, 1'b0);
    drive(4'd1, 3'd2, 16'h0000, 16'h0001);
    tick();
    expect_wr("sub_0m1", 3'd2, 16'hFFFF, 1'b0, 1'b1);
    drive(4'd7, 3'd1, 16'h0000, 16'hBEEF);
    tick();
    expect_wr("mov", 3'd1, 16'hBEEF, 1'b0, 1'b1);

    // Undefined opcode: no write, one-cycle illegal pulse, flags held.
    drive(4'hC, 3'd6, 16'h0001, 16'h0001);
    tick();
    check("ill_c.we", {31'd0, wb_we}, 32'd0);
    check("ill_c.pulse", {31'd0, illegal}, 32'd1);
    check("ill_c.flags", {30'd0, flag_z, flag_c}, 32'b01);
    check("ill_c.hold_addr", {29'd0, wb_addr}, 32'd1);
    idle();
    tick();
    check("ill_c.pulse_end", {31'd0, illegal}, 32'd0);
    check("idle.we", {31'd0, wb_we}, 32'd0);

`ifdef EXEC_WB_MUL_EN
    // 300*300 = 90000 = 0x15F90 -> low half 0x5F90; c (currently 1) must clear.
    drive(4'd9, 3'd6, 16'd300, 16'd300);
    tick();
    drive(4'd0, 3'd0, 16'd1, 16'd2);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("mul.ready_low%0d", i), {31'd0, in_ready}, 32'd0);
      check($sformatf("mul.busy%0d", i), {31'd0, busy}, 32'd1);
      check($sformatf("mul.no_we%0d", i), {31'd0, wb_we}, 32'd0);
      tick();
    end
    expect_wr("mul_wb", 3'd6, 16'h5F90, 1'b0, 1'b0);
    check("mul.ready_back", {31'd0, in_ready}, 32'd1);
    check("mul.busy_end", {31'd0, busy}, 32'd0);
    tick();
    expect_wr("add_after_mul", 3'd0, 16'h0003, 1'b0, 1'b0);
    idle();
    tick();
    check("after_mul.we", {31'd0, wb_we}, 32'd0);

    // Reset during iteration 8 aborts the multiply.
    drive(4'd9, 3'd5, 16'd300, 16'd300);
    tick();
    idle();
    for (int i = 0; i < 8; i++) tick();
    check("abort.busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    expect_reset_outputs("abort_reset");
    rst_n  = 1'b1;
    saw_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wb_we) saw_we = 1'b1;
    end
    check("abort.no_write", {31'd0, saw_we}, 32'd0);
    check("abort.ready", {31'd0, in_ready}, 32'd1);
`else
    // Without the multiplier, opcode 9 is undefined.
    drive(4'd9, 3'd4, 16'd3, 16'd3);
    tick();
    check("mul_off.we", {31'd0, wb_we}, 32'd0);
    check("mul_off.pulse", {31'd0, illegal}, 32'd1);
    check("mul_off.busy", {31'd0, busy}, 32'd0);
    check("mul_off.ready", {31'd0, in_ready}, 32'd1);
    check("mul_off.flags", {30'd0, flag_z, flag_c}, 32'b01);
    idle();
    tick();
    check("mul_off.pulse_end", {31'd0, illegal}, 32'd0);
    check("mul_off.busy_idle", {31'd0, busy}, 32'd0);

    rst_n = 1'b0;
    tick();
    expect_reset_outputs("reset2");
    rst_n = 1'b1;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
